// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Posted-write FIFO between the CPU data port and data memory. A store retires
// on the CPU side in the cycle it is accepted. Buffered stores drain to memory
// in program order, one per cycle, whenever memory signals ready. A load that
// hits a buffered word address is served from the youngest matching entry, so
// the CPU always sees memory as if every store had already landed.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   cpu_we     in   1   CPU store request this cycle
//   cpu_re     in   1   CPU load request this cycle
//   cpu_addr   in   AW  load/store byte address (bits [1:0] ignored)
//   cpu_wdata  in   DW  store data
//   cpu_rdata  out  DW  load data (combinational)
//   cpu_stall  out  1   store not accepted this cycle; CPU holds the request
//   mem_ready  in   1   memory accepts a write this cycle
//   mem_we     out  1   write strobe to memory (buffer non-empty)
//   mem_addr   out  AW  write address of the head entry
//   mem_wdata  out  DW  write data of the head entry
//   mem_raddr  out  AW  read address to memory (= cpu_addr)
//   mem_rdata  in   DW  memory read data (combinational)
//   empty      out  1   no stores pending
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);

  // Entry storage: word address and data. Not reset; validity comes from
  // head/count only.
  logic [AW-3:0] addr_mem_r [DEPTH];
  logic [DW-1:0] data_mem_r [DEPTH];

  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [PW:0]   count_r;
  logic [PW:0]   count_nxt_s;

  // mem_we_r mirrors (count_r != 0) and empty_r mirrors (count_r == 0); both
  // are loaded from the next count so they are plain flops on the outputs.
  logic          mem_we_r;
  logic          empty_r;

  logic          full_s;
  logic          drain_s;
  logic          accept_s;
  logic          wr_en_s;

  logic          hit_s;
  logic [DW-1:0] fwd_data_s;

  // Handshake decode: a full buffer still accepts when the head drains in the
  // same cycle, which keeps the count at DEPTH.
  always_comb begin
    full_s   = (count_r == DEPTH_C);
    drain_s  = mem_we_r & mem_ready;
    accept_s = cpu_we & (~full_s | drain_s);
    wr_en_s  = accept_s & ~rst;
  end

  // Next occupancy: both or neither leave the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({accept_s, drain_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      2'b11:   count_nxt_s = count_r;
      2'b00:   count_nxt_s = count_r;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and status flops; reset discards all pending stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r   <= '0;
      tail_r   <= '0;
      count_r  <= '0;
      mem_we_r <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (drain_s) begin
        head_r <= head_r + PTR_ONE;
      end
      if (accept_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      count_r  <= count_nxt_s;
      mem_we_r <= (count_nxt_s != '0);
      empty_r  <= (count_nxt_s == '0);
    end
  end

  // Entry write at tail on an accepted store.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      addr_mem_r[tail_r] <= cpu_addr[AW-1:2];
      data_mem_r[tail_r] <= cpu_wdata;
    end
  end

  // Forwarding search: walk entries oldest to youngest from head so the last
  // match found is the youngest. The head entry still counts while draining,
  // and a store arriving this cycle is not yet in the array.
  always_comb begin
    hit_s      = 1'b0;
    fwd_data_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < count_r) &&
          (addr_mem_r[head_r + PW'(i)] == cpu_addr[AW-1:2])) begin
        hit_s      = 1'b1;
        fwd_data_s = data_mem_r[head_r + PW'(i)];
      end else begin
        hit_s      = hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  // Load data select.
  always_comb begin
    if (cpu_re & hit_s) begin
      cpu_rdata = fwd_data_s;
    end else begin
      cpu_rdata = mem_rdata;
    end
  end

  assign cpu_stall = cpu_we & ~accept_s;
  assign mem_we    = mem_we_r;
  assign empty     = empty_r;
  assign mem_addr  = {addr_mem_r[head_r], 2'b00};
  assign mem_wdata = data_mem_r[head_r];
  assign mem_raddr = cpu_addr;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        empty;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t log_q[$];

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write memory actually accepts.
  always @(posedge clk) begin
    if (!rst && mem_we && mem_ready) begin
      log_q.push_back('{a: mem_addr, d: mem_wdata});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string tag, input int k, input logic [31:0] a, input logic [31:0] d);
    if (k < log_q.size()) begin
      chk({tag, "_addr"}, {32'h0, log_q[k].a}, {32'h0, a});
      chk({tag, "_data"}, {32'h0, log_q[k].d}, {32'h0, d});
    end else begin
      chk({tag, "_missing"}, 64'(log_q.size()), 64'(k + 1));
    end
  endtask

  initial begin
    int i;
    int cyc;
    bit acc;

    rst       = 1'b1;
    cpu_we    = 1'b0;
    cpu_re    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;

    // Reset state
    #12;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    rst = 1'b0;
    tick();

    // 1: async reset mid-cycle while a store is pending
    log_q.delete();
    cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'd1; mem_ready = 1'b0;
    tick();
    cpu_we = 1'b0;
    chk("t1_pend_empty", 64'(empty), 64'd0);
    chk("t1_pend_mem_we", 64'(mem_we), 64'd1);
    #1;
    rst = 1'b1; cpu_we = 1'b1;
    #1;
    chk("t1_async_empty", 64'(empty), 64'd1);
    chk("t1_async_mem_we", 64'(mem_we), 64'd0);
    chk("t1_async_stall", 64'(cpu_stall), 64'd0);
    #1;
    rst = 1'b0; cpu_we = 1'b0;
    tick();
    mem_ready = 1'b1;
    tick();
    tick();
    chk("t1_no_write", 64'(mem_we), 64'd0);
    chk("t1_log_size", 64'(log_q.size()), 64'd0);

    // 2: single store, visible to memory one cycle later
    log_q.delete();
    mem_ready = 1'b1;
    cpu_we = 1'b1; cpu_addr = 32'h0C; cpu_wdata = 32'd45;
    #1;
    chk("t2_stall", 64'(cpu_stall), 64'd0);
    chk("t2_no_bypass", 64'(mem_we), 64'd0);
    tick();
    cpu_we = 1'b0;
    chk("t2_mem_we", 64'(mem_we), 64'd1);
    chk("t2_mem_addr", 64'(mem_addr), 64'h0C);
    chk("t2_mem_wdata", 64'(mem_wdata), 64'd45);
    chk("t2_not_empty", 64'(empty), 64'd0);
    tick();
    chk("t2_empty", 64'(empty), 64'd1);
    chk("t2_idle", 64'(mem_we), 64'd0);
    chk("t2_log_size", 64'(log_q.size()), 64'd1);
    chk_log("t2_log0", 0, 32'h0C, 32'd45);

    // 3: fill, stall, then accept while draining when full
    log_q.delete();
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cpu_we = 1'b1; cpu_addr = 32'(4 * k); cpu_wdata = 32'(100 + k);
      tick();
    end
    cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'd200;
    #1;
    chk("t3_full_stall", 64'(cpu_stall), 64'd1);
    chk("t3_head_addr", 64'(mem_addr), 64'h0);
    tick();
    chk("t3_hold_stall", 64'(cpu_stall), 64'd1);
    mem_ready = 1'b1;
    #1;
    chk("t3_accept", 64'(cpu_stall), 64'd0);
    tick();
    cpu_we = 1'b0;
    chk("t3_head_next", 64'(mem_addr), 64'h4);
    mem_ready = 1'b0; cpu_we = 1'b1; cpu_addr = 32'h50;
    #1;
    chk("t3_still_full", 64'(cpu_stall), 64'd1);
    cpu_we = 1'b0; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("t3_empty", 64'(empty), 64'd1);
    chk("t3_log_size", 64'(log_q.size()), 64'd5);
    chk_log("t3_log0", 0, 32'h00, 32'd100);
    chk_log("t3_log1", 1, 32'h04, 32'd101);
    chk_log("t3_log2", 2, 32'h08, 32'd102);
    chk_log("t3_log3", 3, 32'h0C, 32'd103);
    chk_log("t3_log4", 4, 32'h30, 32'd200);

    // 4: forwarding
    log_q.delete();
    mem_ready = 1'b0;
    cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'd7;
    tick();
    cpu_wdata = 32'd9;
    tick();
    cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h10;
    #1;
    chk("t4_fwd_young", 64'(cpu_rdata), 64'd9);
    chk("t4_raddr", 64'(mem_raddr), 64'h10);
    cpu_addr = 32'h12;
    #1;
    chk("t4_fwd_byteoff", 64'(cpu_rdata), 64'd9);
    cpu_addr = 32'h14;
    #1;
    chk("t4_miss", 64'(cpu_rdata), 64'hDEAD_BEEF);
    cpu_we = 1'b1; cpu_wdata = 32'd55;
    #1;
    chk("t4_same_cycle", 64'(cpu_rdata), 64'hDEAD_BEEF);
    tick();
    cpu_we = 1'b0;
    chk("t4_fwd_new", 64'(cpu_rdata), 64'd55);
    mem_ready = 1'b1;
    tick();
    tick();
    chk("t4_fwd_draining", 64'(cpu_rdata), 64'd55);
    tick();
    chk("t4_after_drain", 64'(cpu_rdata), 64'hDEAD_BEEF);
    cpu_re = 1'b0;
    chk("t4_log_size", 64'(log_q.size()), 64'd3);
    chk_log("t4_log0", 0, 32'h10, 32'd7);
    chk_log("t4_log1", 1, 32'h10, 32'd9);
    chk_log("t4_log2", 2, 32'h14, 32'd55);

    // 5: reset discards a pending store
    log_q.delete();
    mem_ready = 1'b0;
    cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'd1;
    tick();
    cpu_we = 1'b0;
    chk("t5_pending", 64'(empty), 64'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_empty", 64'(empty), 64'd1);
    chk("t5_rst_mem_we", 64'(mem_we), 64'd0);
    #2;
    rst = 1'b0;
    tick();
    mem_ready = 1'b1;
    tick();
    tick();
    chk("t5_no_mem_we", 64'(mem_we), 64'd0);
    chk("t5_log_size", 64'(log_q.size()), 64'd0);

    // 6: 3*DEPTH stores with mem_ready toggling; pointers wrap
    log_q.delete();
    i = 0;
    cyc = 0;
    while (i < 12 && cyc < 200) begin
      mem_ready = (cyc % 2 == 0);
      cpu_we = 1'b1; cpu_addr = 32'(32'h100 + 4 * i); cpu_wdata = 32'(1000 + i);
      #1;
      acc = !cpu_stall;
      tick();
      if (acc) i++;
      cyc++;
    end
    cpu_we = 1'b0;
    chk("t6_all_issued", 64'(i), 64'd12);
    mem_ready = 1'b1;
    cyc = 0;
    while (!empty && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("t6_empty", 64'(empty), 64'd1);
    chk("t6_log_size", 64'(log_q.size()), 64'd12);
    for (int k = 0; k < 12; k++) begin
      chk_log($sformatf("t6_log%0d", k), k, 32'(32'h100 + 4 * k), 32'(1000 + k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
